// File: rtl/mem_access_unit_if.sv
// CPU-side load/store request/response bundle for mem_access_unit.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic                  write;
  logic [2:0]            mode;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic [31:0]           read_data;
  logic                  done;
  logic                  error;
  logic                  active;

  modport master (
    output start, write, mode, address, write_data,
    input  read_data, done, error, active
  );

  modport slave (
    input  start, write, mode, address, write_data,
    output read_data, done, error, active
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store unit on a 1/2/4-byte RAM port with wait states.
// Optional MEM_ACCESS_MISALIGNED_EN: split misaligned accesses into byte beats.
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BUS_BYTES   = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_unit_if.slave       cpu,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [8*BUS_BYTES-1:0] mem_write_data,
  output logic [BUS_BYTES-1:0]   mem_write_enable,
  input  logic [8*BUS_BYTES-1:0] mem_read_data
);

  localparam int LW    = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1;
  localparam int SHIFT = $clog2(BUS_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BUS_BYTES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t                 r_state;
  logic                   r_write;
  logic [2:0]             r_mode;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [31:0]            r_wdata;
  logic                   r_split;
  logic [2:0]             r_size;
  logic [2:0]             r_nbeats;
  logic [2:0]             r_beat;
  logic [3:0]             r_wait;
  logic [31:0]            r_buf;
  logic [31:0]            r_read_data;
  logic                   r_done;
  logic                   r_error;
  logic                   r_active;
  logic [ADDR_WIDTH-1:0]  r_mem_address;
  logic [8*BUS_BYTES-1:0] r_mem_wdata;
  logic [BUS_BYTES-1:0]   r_mem_we;

  function automatic logic [2:0] size_of(input logic [2:0] mode);
    case (mode[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic mode_legal(input logic [2:0] mode, input logic wr);
    case (mode)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !wr;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] beat_count(input logic [2:0] size, input logic split);
    if (split || (BUS_BYTES == 1))   return size;
    else if (size > 3'(BUS_BYTES))   return size / 3'(BUS_BYTES);
    else                             return 3'd1;
  endfunction

  function automatic logic [LW-1:0] lane_of(input logic [ADDR_WIDTH-1:0] ba);
    return LW'(ba & LANE_MASK);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [ADDR_WIDTH-1:0] addr, input logic split, input logic [2:0] k);
    if (split) return (addr + ADDR_WIDTH'(k)) & ~LANE_MASK;
    else       return (addr & ~LANE_MASK) + (ADDR_WIDTH'(k) << SHIFT);
  endfunction

  // Which access bytes (0..3) belong to beat k whose word address is waddr.
  function automatic logic [3:0] beat_sel(
    input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size, input logic split,
    input logic [ADDR_WIDTH-1:0] waddr, input logic [2:0] k);
    logic [ADDR_WIDTH-1:0] ba;
    logic [3:0]            sel;
    sel = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      ba = addr + ADDR_WIDTH'(j);
      if ((3'(j) < size) && (split ? (3'(j) == k) : ((ba & ~LANE_MASK) == waddr)))
        sel[j] = 1'b1;
    end
    return sel;
  endfunction

  function automatic logic [BUS_BYTES-1:0] lanes_of(
    input logic [ADDR_WIDTH-1:0] addr, input logic [3:0] sel);
    logic [BUS_BYTES-1:0] lanes;
    lanes = '0;
    for (int unsigned j = 0; j < 4; j++)
      if (sel[j]) lanes[lane_of(addr + ADDR_WIDTH'(j))] = 1'b1;
    return lanes;
  endfunction

  function automatic logic [8*BUS_BYTES-1:0] wdata_of(
    input logic [ADDR_WIDTH-1:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
    logic [8*BUS_BYTES-1:0] wl;
    wl = '0;
    for (int unsigned j = 0; j < 4; j++)
      if (sel[j]) wl[lane_of(addr + ADDR_WIDTH'(j))*8 +: 8] = wdata[j*8 +: 8];
    return wl;
  endfunction

  logic [2:0]             w_in_size;
  logic                   w_in_mis;
  logic                   w_in_split;
  logic                   w_in_err;
  logic [ADDR_WIDTH-1:0]  w_a_addr;
  logic [3:0]             w_a_sel;
  logic [3:0]             w_c_sel;
  logic [ADDR_WIDTH-1:0]  w_n_addr;
  logic [3:0]             w_n_sel;
  logic [31:0]            w_buf_next;
  logic [31:0]            w_ext;

  always_comb begin
    w_in_size = size_of(cpu.mode);
    w_in_mis  = (cpu.address & ADDR_WIDTH'(w_in_size - 3'd1)) != '0;
`ifdef MEM_ACCESS_MISALIGNED_EN
    w_in_split = w_in_mis;
    w_in_err   = !mode_legal(cpu.mode, cpu.write);
`else
    w_in_split = 1'b0;
    w_in_err   = !mode_legal(cpu.mode, cpu.write) || w_in_mis;
`endif
    w_a_addr = beat_addr(cpu.address, w_in_split, 3'd0);
    w_a_sel  = beat_sel(cpu.address, w_in_size, w_in_split, w_a_addr, 3'd0);
    w_c_sel  = beat_sel(r_addr, r_size, r_split, r_mem_address, r_beat);
    w_n_addr = beat_addr(r_addr, r_split, r_beat + 3'd1);
    w_n_sel  = beat_sel(r_addr, r_size, r_split, w_n_addr, r_beat + 3'd1);

    w_buf_next = r_buf;
    for (int unsigned j = 0; j < 4; j++)
      if (w_c_sel[j])
        w_buf_next[j*8 +: 8] = mem_read_data[lane_of(r_addr + ADDR_WIDTH'(j))*8 +: 8];

    case (r_size)
      3'd1:    w_ext = r_mode[2] ? {24'b0, w_buf_next[7:0]}
                                 : {{24{w_buf_next[7]}}, w_buf_next[7:0]};
      3'd2:    w_ext = r_mode[2] ? {16'b0, w_buf_next[15:0]}
                                 : {{16{w_buf_next[15]}}, w_buf_next[15:0]};
      default: w_ext = w_buf_next;
    endcase
  end

  // Write strobes are registered, so they are set one edge ahead of a beat's last cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_write       <= 1'b0;
      r_mode        <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_split       <= 1'b0;
      r_size        <= '0;
      r_nbeats      <= '0;
      r_beat        <= '0;
      r_wait        <= '0;
      r_buf         <= '0;
      r_read_data   <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_active      <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_we      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done   <= 1'b0;
          r_error  <= 1'b0;
          r_mem_we <= '0;
          if (cpu.start) begin
            r_write  <= cpu.write;
            r_mode   <= cpu.mode;
            r_addr   <= cpu.address;
            r_wdata  <= cpu.write_data;
            r_split  <= w_in_split;
            r_size   <= w_in_size;
            r_nbeats <= beat_count(w_in_size, w_in_split);
            r_active <= 1'b1;
            if (w_in_err) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state       <= ST_ACCESS;
              r_beat        <= '0;
              r_wait        <= 4'(WAIT_STATES);
              r_buf         <= '0;
              r_mem_address <= w_a_addr;
              r_mem_wdata   <= cpu.write ? wdata_of(cpu.address, w_a_sel, cpu.write_data) : '0;
              r_mem_we      <= (cpu.write && (WAIT_STATES == 0))
                               ? lanes_of(cpu.address, w_a_sel) : '0;
            end
          end
        end
        ST_ACCESS: begin
          if (r_wait == 4'd0) begin
            if (!r_write) r_buf <= w_buf_next;
            if (r_beat == r_nbeats - 3'd1) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_mem_we <= '0;
              if (!r_write) r_read_data <= w_ext;
            end else begin
              r_beat        <= r_beat + 3'd1;
              r_wait        <= 4'(WAIT_STATES);
              r_mem_address <= w_n_addr;
              r_mem_wdata   <= r_write ? wdata_of(r_addr, w_n_sel, r_wdata) : '0;
              r_mem_we      <= (r_write && (WAIT_STATES == 0)) ? lanes_of(r_addr, w_n_sel) : '0;
            end
          end else begin
            r_wait   <= r_wait - 4'd1;
            r_mem_we <= (r_write && (r_wait == 4'd1)) ? lanes_of(r_addr, w_c_sel) : '0;
          end
        end
        default: begin
          r_done   <= 1'b0;
          r_error  <= 1'b0;
          r_active <= 1'b0;
          r_mem_we <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu.read_data    = r_read_data;
  assign cpu.done         = r_done;
  assign cpu.error        = r_error;
  assign cpu.active       = r_active;
  assign mem_address      = r_mem_address;
  assign mem_write_data   = r_mem_wdata;
  assign mem_write_enable = r_mem_we;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench: two configurations (1-byte/0-wait, 4-byte/2-wait) driven in lockstep
// against a byte-array reference model of RAM and the load/store rules.
module tb_mem_access_unit;
  localparam int AW   = 32;
  localparam int BB_A = 1;
  localparam int WS_A = 0;
  localparam int BB_B = 4;
  localparam int WS_B = 2;
`ifdef MEM_ACCESS_MISALIGNED_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(AW)) ifa ();
  mem_access_unit_if #(.ADDR_WIDTH(AW)) ifb ();

  logic [AW-1:0] ma_addr, mb_addr;
  logic [7:0]    ma_wd, ma_rd;
  logic [0:0]    ma_we;
  logic [31:0]   mb_wd, mb_rd;
  logic [3:0]    mb_we;

  mem_access_unit #(.ADDR_WIDTH(AW), .BUS_BYTES(BB_A), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst(rst), .cpu(ifa),
    .mem_address(ma_addr), .mem_write_data(ma_wd),
    .mem_write_enable(ma_we), .mem_read_data(ma_rd));

  mem_access_unit #(.ADDR_WIDTH(AW), .BUS_BYTES(BB_B), .WAIT_STATES(WS_B)) dut_b (
    .clk(clk), .rst(rst), .cpu(ifb),
    .mem_address(mb_addr), .mem_write_data(mb_wd),
    .mem_write_enable(mb_we), .mem_read_data(mb_rd));

  logic [7:0] rama [1024];
  logic [7:0] ramb [1024];
  logic [7:0] exp_mem [1024];

  always_comb ma_rd = rama[ma_addr[9:0]];
  always_comb begin
    mb_rd = '0;
    for (int l = 0; l < 4; l++) mb_rd[l*8 +: 8] = ramb[mb_addr[9:0] + 10'(l)];
  end

  always @(posedge clk) begin
    if (ma_we[0]) rama[ma_addr[9:0]] = ma_wd;
    for (int l = 0; l < 4; l++)
      if (mb_we[l]) ramb[mb_addr[9:0] + 10'(l)] = mb_wd[l*8 +: 8];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string sfx);
    check_eq({"rd_",   sfx}, ifa.read_data, 32'h0);
    check_eq({"done_", sfx}, {ifa.done, ifb.done}, 32'h0);
    check_eq({"err_",  sfx}, {ifa.error, ifb.error}, 32'h0);
    check_eq({"act_",  sfx}, {ifa.active, ifb.active}, 32'h0);
    check_eq({"maddr_a_", sfx}, ma_addr, 32'h0);
    check_eq({"maddr_b_", sfx}, mb_addr, 32'h0);
    check_eq({"mwd_",  sfx}, {ma_wd, mb_wd[23:0]} | {24'h0, mb_wd[31:24]}, 32'h0);
    check_eq({"mwe_",  sfx}, {ma_we, mb_we}, 32'h0);
    check_eq({"rd_b_", sfx}, ifb.read_data, 32'h0);
  endtask

  task automatic drive(input logic st, input logic w, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wd);
    ifa.start = st; ifa.write = w; ifa.mode = mode; ifa.address = addr; ifa.write_data = wd;
    ifb.start = st; ifb.write = w; ifb.mode = mode; ifb.address = addr; ifb.write_data = wd;
  endtask

  int          lat_a, lat_b, we_cnt_a, we_cnt_b;
  logic        err_a, err_b;
  logic [31:0] rd_a, rd_b;
  bit          act_ok_a, act_ok_b, align_ok_b;
  logic [31:0] addr_log_a [64];
  logic [31:0] addr_log_b [64];
  logic [31:0] we_log_b   [64];
  logic [31:0] wd_log_b   [64];
  logic [31:0] exp_rd;

  task automatic run_req(input logic w, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wd, input bit pulse);
    @(negedge clk);
    drive(1'b1, w, mode, addr, wd);
    lat_a = 0; lat_b = 0; we_cnt_a = 0; we_cnt_b = 0;
    act_ok_a = 1'b1; act_ok_b = 1'b1; align_ok_b = 1'b1;
    for (int s = 1; s < 64 && (lat_a == 0 || lat_b == 0); s++) begin
      @(negedge clk);
      if (s == 1) drive(1'b0, w, mode, addr, wd);
      if (pulse && s == 2) drive(1'b1, !w, 3'b010, addr ^ 32'h40, ~wd);
      if (pulse && s == 3) drive(1'b0, w, mode, addr, wd);
      addr_log_a[s] = ma_addr;
      addr_log_b[s] = mb_addr;
      we_log_b[s]   = {28'h0, mb_we};
      wd_log_b[s]   = mb_wd;
      if (lat_a == 0) begin
        if (ma_we != '0) we_cnt_a++;
        if (!ifa.active) act_ok_a = 1'b0;
        if (ifa.done) begin lat_a = s; err_a = ifa.error; rd_a = ifa.read_data; end
      end
      if (lat_b == 0) begin
        if (mb_we != '0) we_cnt_b++;
        if (!ifb.active) act_ok_b = 1'b0;
        if (mb_addr[1:0] != 2'b00) align_ok_b = 1'b0;
        if (ifb.done) begin lat_b = s; err_b = ifb.error; rd_b = ifb.read_data; end
      end
    end
    drive(1'b0, w, mode, addr, wd);
  endtask

  function automatic logic [31:0] load_val(input logic [2:0] mode, input logic [31:0] addr,
                                           input int unsigned n);
    logic [31:0] v;
    v = '0;
    for (int unsigned j = 0; j < n; j++) v |= 32'(exp_mem[10'(addr + j)]) << (8 * j);
    case (mode)
      3'b000:  v = {{24{v[7]}}, v[7:0]};
      3'b001:  v = {{16{v[15]}}, v[15:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic do_req(input logic w, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wd, input bit pulse);
    int unsigned n, beats_a, beats_b, exp_lat_a, exp_lat_b, exp_we_a, exp_we_b;
    bit legal, mis, err;
    logic [9:0] idx;
    n     = (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
    legal = (mode inside {3'b000, 3'b001, 3'b010}) || (!w && (mode inside {3'b100, 3'b101}));
    mis   = (addr % n) != 0;
    err   = !legal || (mis && !MIS_EN);
    beats_a = mis ? n : ((n > BB_A) ? n / BB_A : 1);
    beats_b = mis ? n : ((n > BB_B) ? n / BB_B : 1);
    exp_lat_a = err ? 1 : beats_a * (WS_A + 1) + 1;
    exp_lat_b = err ? 1 : beats_b * (WS_B + 1) + 1;
    exp_we_a  = (w && !err) ? beats_a : 0;
    exp_we_b  = (w && !err) ? beats_b : 0;
    run_req(w, mode, addr, wd, pulse && !err);
    if (!err) begin
      if (w) for (int unsigned j = 0; j < n; j++) exp_mem[10'(addr + j)] = wd[8*j +: 8];
      else   exp_rd = load_val(mode, addr, n);
    end
    check_eq("lat_a", 32'(lat_a), 32'(exp_lat_a));
    check_eq("lat_b", 32'(lat_b), 32'(exp_lat_b));
    check_eq("err_a", {31'h0, err_a}, {31'h0, err});
    check_eq("err_b", {31'h0, err_b}, {31'h0, err});
    check_eq("rdata_a", rd_a, exp_rd);
    check_eq("rdata_b", rd_b, exp_rd);
    check_eq("wecnt_a", 32'(we_cnt_a), 32'(exp_we_a));
    check_eq("wecnt_b", 32'(we_cnt_b), 32'(exp_we_b));
    check_eq("align_b", {31'h0, align_ok_b}, 32'h1);
    if (!err) check_eq("active", {30'h0, act_ok_a, act_ok_b}, 32'h3);
    if (w) begin
      for (int unsigned j = 0; j < n + 2; j++) begin
        idx = 10'(addr + j - 1);
        check_eq("ram_a", 32'(rama[idx]), 32'(exp_mem[idx]));
        check_eq("ram_b", 32'(ramb[idx]), 32'(exp_mem[idx]));
      end
    end
  endtask

  task automatic set_byte(input logic [9:0] a, input logic [7:0] v);
    rama[a] = v; ramb[a] = v; exp_mem[a] = v;
  endtask

  initial begin
    logic [2:0]  mode;
    logic [31:0] addr;
    int unsigned n, k;
    exp_rd = '0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 1024; i++) set_byte(10'(i), 8'($urandom));
    #2 rst = 1'b0;
    #2 check_quiet("reset");
    @(negedge clk);
    rst = 1'b1;

    // LW at 0x100, bytes 78 56 34 12
    set_byte(10'h100, 8'h78); set_byte(10'h101, 8'h56);
    set_byte(10'h102, 8'h34); set_byte(10'h103, 8'h12);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
    check_eq("lw_value", rd_a, 32'h12345678);
    for (int i = 0; i < 4; i++) check_eq("lw_addr_a", addr_log_a[i+1], 32'h100 + 32'(i));

    // LB / LBU at 0x203, word 0x80FFFFFF
    set_byte(10'h200, 8'hFF); set_byte(10'h201, 8'hFF);
    set_byte(10'h202, 8'hFF); set_byte(10'h203, 8'h80);
    do_req(1'b0, 3'b000, 32'h203, 32'h0, 1'b0);
    check_eq("lb_value", rd_b, 32'hFFFFFF80);
    check_eq("lb_addr_b", addr_log_b[1], 32'h200);
    do_req(1'b0, 3'b100, 32'h203, 32'h0, 1'b0);
    check_eq("lbu_value", rd_b, 32'h00000080);

    // SH 0xABCD at 0x302 on the 4-byte, 2-wait port
    do_req(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 1'b0);
    for (int s = 1; s <= 3; s++) begin
      check_eq("sh_addr_b", addr_log_b[s], 32'h300);
      check_eq("sh_we_b", we_log_b[s], (s == 3) ? 32'hC : 32'h0);
    end
    check_eq("sh_wdata_b", {16'h0, wd_log_b[3][31:16]}, 32'hABCD);

    // Misaligned LW, illegal mode, misaligned SW
    do_req(1'b0, 3'b010, 32'h101, 32'h0, 1'b0);
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
    do_req(1'b1, 3'b010, 32'h101, 32'hDEADBEEF, 1'b0);
`ifdef MEM_ACCESS_MISALIGNED_EN
    k = 0;
    for (int s = 1; s <= lat_b; s++) begin
      if (we_log_b[s] != 32'h0) begin
        case (k)
          0: begin check_eq("mis_addr0", addr_log_b[s], 32'h100); check_eq("mis_we0", we_log_b[s], 32'h2); end
          1: begin check_eq("mis_addr1", addr_log_b[s], 32'h100); check_eq("mis_we1", we_log_b[s], 32'h4); end
          2: begin check_eq("mis_addr2", addr_log_b[s], 32'h100); check_eq("mis_we2", we_log_b[s], 32'h8); end
          default: begin check_eq("mis_addr3", addr_log_b[s], 32'h104); check_eq("mis_we3", we_log_b[s], 32'h1); end
        endcase
        k++;
      end
    end
    check_eq("mis_beats", 32'(k), 32'd4);
`endif

    // Reset during the second beat of a store
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b010, 32'h40, 32'h11223344);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344);
    @(negedge clk);
    rst = 1'b0;
    #1 check_quiet("midreset");
    @(negedge clk);
    check_quiet("held");
    rst = 1'b1;
    for (int i = 'h40; i < 'h44; i++) begin rama[i] = exp_mem[i]; ramb[i] = exp_mem[i]; end
    exp_rd = '0;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      k    = $urandom_range(0, 9);
      mode = (k > 7) ? 3'b010 : 3'(k);
      n    = (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
      addr = 32'($urandom_range(1, 32'h3F7));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
      do_req(1'($urandom), mode, addr, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
